// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit: access-size encodings and FSM states.
package lsu_pkg;

    // Access size encodings on req_size; 2'b11 decodes the same as a word.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_WB   = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Request, memory and writeback signals of the load-store unit.
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; the valid side holds its payload stable until then.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_data;

    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;

    // The unit itself.
    modport slave (
        input  req_valid, req_load, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_req_valid, mem_addr, mem_we, mem_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output wb_valid, wb_rd, wb_data
    );

    // The pipeline/memory environment around the unit.
    modport master (
        output req_valid, req_load, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_req_valid, mem_addr, mem_we, mem_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extract / sign-extend for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_we,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Store: replicate the data across lanes and enable only the addressed bytes.
    always_comb begin
        st_we    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_we    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_we    = 4'b0011 << {st_off[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load: bring the addressed lane down to bit 0, then zero- or sign-extend.
    always_comb begin
        shifted = ld_raw;
        ld_data = ld_raw;
        case (ld_size)
            SZ_BYTE: begin
                shifted = ld_raw >> {ld_off, 3'b000};
                ld_data = ld_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                shifted = ld_raw >> {ld_off[1], 4'b0000};
                ld_data = ld_unsigned ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MIPS150 load-store unit: one word-aligned memory access in flight at a time.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are
// dropped with a one-cycle misaligned pulse instead of being force-aligned.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    load_store_unit_if.slave        bus,
    output logic                    misaligned,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    lsu_state_e  state;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;
    logic        load_q;
    logic [4:0]  rd_q;
    logic        trap;
    logic [3:0]  st_we;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign dbg_state = state;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                  (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
    // Misaligned low bits are simply ignored: the word address drops [1:0]
    // and the half extract only looks at offset bit 1.
    assign trap = 1'b0;
`endif

    lsu_align u_align (
        .st_size     (bus.req_size),
        .st_off      (bus.req_addr[1:0]),
        .st_data     (bus.req_wdata),
        .st_we       (st_we),
        .st_wdata    (st_wdata),
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_unsigned (uns_q),
        .ld_raw      (bus.mem_resp_data),
        .ld_data     (ld_data)
    );

    // Access FSM with all handshake and writeback outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            bus.req_ready     <= 1'b1;
            bus.mem_req_valid <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_we        <= 4'b0000;
            bus.mem_wdata     <= 32'h0;
            bus.wb_valid      <= 1'b0;
            bus.wb_rd         <= 5'd0;
            bus.wb_data       <= 32'h0;
            misaligned        <= 1'b0;
            busy              <= 1'b0;
            size_q            <= SZ_BYTE;
            off_q             <= 2'b00;
            uns_q             <= 1'b0;
            load_q            <= 1'b0;
            rd_q              <= 5'd0;
        end else begin
            bus.wb_valid <= 1'b0;
            misaligned   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        size_q        <= bus.req_size;
                        off_q         <= bus.req_addr[1:0];
                        uns_q         <= bus.req_unsigned;
                        load_q        <= bus.req_load;
                        rd_q          <= bus.req_rd;
                        bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        bus.mem_we    <= bus.req_load ? 4'b0000 : st_we;
                        bus.mem_wdata <= st_wdata;
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        if (trap) begin
                            // Dropped access: pass through WB without a writeback.
                            misaligned <= 1'b1;
                            state      <= S_WB;
                        end else begin
                            bus.mem_req_valid <= 1'b1;
                            state             <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        if (load_q) begin
                            state <= S_WAIT;
                        end else begin
                            state         <= S_IDLE;
                            bus.req_ready <= 1'b1;
                            busy          <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        bus.wb_data  <= ld_data;
                        bus.wb_rd    <= rd_q;
                        bus.wb_valid <= 1'b1;
                        state        <= S_WB;
                    end
                end
                S_WB: begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b1;
                    busy          <= 1'b0;
                end
                default: begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b1;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, stalls, misalignment and reset mid-access.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       misaligned;
    logic       busy;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;
    int wb_cnt = 0;
    logic wb_prev = 1'b0;
    logic [36:0] exp_q[$];

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .misaligned (misaligned),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Writeback scoreboard: every wb_valid must match the head of exp_q.
    always @(negedge clk) begin
        if (bus.wb_valid) begin
            wb_cnt++;
            if (wb_prev) check("wb_pulse_len", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wb_data", bus.wb_data, e[31:0]);
                check("wb_rd", {27'h0, bus.wb_rd}, {27'h0, e[36:32]});
            end
        end
        wb_prev = bus.wb_valid;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, {31'h0, bus.req_ready}, 32'd1);
        check({tag, "_mem_req_valid"}, {31'h0, bus.mem_req_valid}, 32'd0);
        check({tag, "_mem_we"}, {28'h0, bus.mem_we}, 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_wb_valid"}, {31'h0, bus.wb_valid}, 32'd0);
        check({tag, "_wb_rd"}, {27'h0, bus.wb_rd}, 32'd0);
        check({tag, "_wb_data"}, bus.wb_data, 32'd0);
        check({tag, "_misaligned"}, {31'h0, misaligned}, 32'd0);
        check({tag, "_busy"}, {31'h0, busy}, 32'd0);
        check({tag, "_state"}, {30'h0, dbg_state}, {30'h0, S_IDLE});
    endtask

    // Driver: present one access and return just after the accepting edge.
    task automatic issue(input logic ld, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            check("issue_timeout", 32'd0, 32'd1);
            return;
        end
        bus.req_valid    = 1'b1;
        bus.req_load     = ld;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Memory side: check the request, stall rdly cycles, then (for loads)
    // respond after pdly wait cycles. junk raises a bogus response in the
    // request handshake cycle, which the unit must ignore.
    task automatic serve(input int rdly, input int pdly, input logic ld, input logic junk,
                         input logic [31:0] rdata, input logic [31:0] e_addr,
                         input logic [3:0] e_we, input logic [31:0] e_wdata);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.mem_req_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.mem_req_valid) begin
            check("mem_req_timeout", 32'd0, 32'd1);
            return;
        end
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_we", {28'h0, bus.mem_we}, {28'h0, e_we});
        if (!ld) check("mem_wdata", bus.mem_wdata, e_wdata);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check("hold_valid", {31'h0, bus.mem_req_valid}, 32'd1);
            check("hold_addr", bus.mem_addr, e_addr);
            check("hold_ready_low", {31'h0, bus.req_ready}, 32'd0);
        end
        bus.mem_req_ready = 1'b1;
        if (junk) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'hBAD0_BAD0;
        end
        @(posedge clk);
        #1;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        if (ld) begin
            for (int i = 0; i < pdly; i++) begin
                @(negedge clk);
                check("wait_ready_low", {31'h0, bus.req_ready}, 32'd0);
                check("wait_no_wb", {31'h0, bus.wb_valid}, 32'd0);
            end
            @(negedge clk);
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = rdata;
            @(posedge clk);
            #1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = 32'h0;
        end
    endtask

    task automatic do_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] raw, input logic [31:0] exp,
                           input logic [31:0] e_addr, input int rdly, input int pdly, input logic junk);
        int c0;
        c0 = wb_cnt;
        exp_q.push_back({rd, exp});
        issue(1'b1, sz, uns, addr, 32'h0, rd);
        serve(rdly, pdly, 1'b1, junk, raw, e_addr, 4'b0000, 32'h0);
        repeat (3) @(negedge clk);
        check("wb_count", wb_cnt - c0, 32'd1);
        check("idle_after_load", {31'h0, bus.req_ready}, 32'd1);
    endtask

    task automatic do_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] e_addr, input logic [3:0] e_we, input logic [31:0] e_wd);
        issue(1'b0, sz, 1'b0, addr, wd, 5'd0);
        serve(0, 0, 1'b0, 1'b0, 32'h0, e_addr, e_we, e_wd);
        @(negedge clk);
        check("store_idle_c2", {31'h0, bus.req_ready}, 32'd1);
        check("store_busy_c2", {31'h0, busy}, 32'd0);
        check("store_valid_c2", {31'h0, bus.mem_req_valid}, 32'd0);
    endtask

    initial begin
        int c0;
        bus.req_valid      = 1'b0;
        bus.req_load       = 1'b0;
        bus.req_size       = SZ_BYTE;
        bus.req_unsigned   = 1'b0;
        bus.req_addr       = 32'h0;
        bus.req_wdata      = 32'h0;
        bus.req_rd         = 5'd0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;

        // Reset
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;

        // SB at 0x1003: lane 3, replicated data
        do_store(SZ_BYTE, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);

        // SH at 0x6002 and SW at 0x7000
        do_store(SZ_HALF, 32'h0000_6002, 32'h0000_1234, 32'h0000_6000, 4'b1100, 32'h1234_1234);
        do_store(SZ_WORD, 32'h0000_7000, 32'hCAFE_F00D, 32'h0000_7000, 4'b1111, 32'hCAFE_F00D);

        // LH signed, upper half
        do_load(SZ_HALF, 1'b0, 32'h0000_2002, 5'd7, 32'h8001_1234, 32'hFFFF_8001, 32'h0000_2000, 0, 0, 1'b0);
        // LBU / LB on lane 1
        do_load(SZ_BYTE, 1'b1, 32'h0000_2001, 5'd9, 32'h0000_F100, 32'h0000_00F1, 32'h0000_2000, 0, 0, 1'b0);
        do_load(SZ_BYTE, 1'b0, 32'h0000_2001, 5'd10, 32'h0000_F100, 32'hFFFF_FFF1, 32'h0000_2000, 0, 0, 1'b0);
        // LHU lower half, word load with unsigned flag ignored
        do_load(SZ_HALF, 1'b1, 32'h0000_6000, 5'd3, 32'hBEEF_9ABC, 32'h0000_9ABC, 32'h0000_6000, 0, 0, 1'b0);
        do_load(2'b11, 1'b1, 32'h0000_6004, 5'd4, 32'h8765_4321, 32'h8765_4321, 32'h0000_6004, 0, 0, 1'b0);

        // Stalled request (5 cycles) and delayed response (3 cycles), bogus resp during handshake
        do_load(SZ_WORD, 1'b0, 32'h0000_4000, 5'd12, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_4000, 5, 3, 1'b1);

        // Misaligned LW at 0x3002
`ifdef LSU_MISALIGN_TRAP_EN
        c0 = wb_cnt;
        issue(1'b1, SZ_WORD, 1'b0, 32'h0000_3002, 32'h0, 5'd5);
        @(negedge clk);
        check("mis_pulse", {31'h0, misaligned}, 32'd1);
        check("mis_no_req", {31'h0, bus.mem_req_valid}, 32'd0);
        check("mis_no_wb", {31'h0, bus.wb_valid}, 32'd0);
        @(negedge clk);
        check("mis_pulse_end", {31'h0, misaligned}, 32'd0);
        check("mis_idle", {31'h0, bus.req_ready}, 32'd1);
        check("mis_wb_count", wb_cnt - c0, 32'd0);
`else
        do_load(SZ_WORD, 1'b0, 32'h0000_3002, 5'd5, 32'h1234_5678, 32'h1234_5678, 32'h0000_3000, 0, 0, 1'b0);
        check("mis_tied_low", {31'h0, misaligned}, 32'd0);
`endif

        // Reset while waiting for a load response; the late response must be ignored
        c0 = wb_cnt;
        issue(1'b1, SZ_WORD, 1'b0, 32'h0000_5000, 32'h0, 5'd20);
        @(negedge clk);
        check("rw_req_valid", {31'h0, bus.mem_req_valid}, 32'd1);
        bus.mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        check("rw_in_wait", {30'h0, dbg_state}, {30'h0, S_WAIT});
        rst = 1'b1;
        #1;
        check_reset_vals("rw");
        @(negedge clk);
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        bus.mem_resp_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rw_no_wb", wb_cnt - c0, 32'd0);
        check("rw_idle", {31'h0, bus.req_ready}, 32'd1);

        // Normal traffic after the reset
        do_store(SZ_BYTE, 32'h0000_8000, 32'h0000_0042, 32'h0000_8000, 4'b0001, 32'h4242_4242);
        do_load(SZ_BYTE, 1'b0, 32'h0000_8002, 5'd31, 32'h0080_0000, 32'hFFFF_FF80, 32'h0000_8000, 1, 1, 1'b0);

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
